// File: rtl/alu_arbiter_if.sv
// Requester and response channels of the shared-ALU arbiter.
// The master side belongs to the clients and the consumer; the slave side belongs to the arbiter.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ*4-1:0] req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 8-bit ALU between NUM_REQ requesters.
// One operation is in flight at a time: IDLE accepts, EXEC captures alu_out, RESP holds the response.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic [3:0]   alu_sel,
    input  logic [7:0]   alu_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [3:0]      OP_DIV    = 4'b0011;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            err_q, err_d;
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic [3:0]      alu_sel_q, alu_sel_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic            rsp_err_q, rsp_err_d;

    logic [7:0]      a_arr  [NUM_REQ];
    logic [7:0]      b_arr  [NUM_REQ];
    logic [3:0]      op_arr [NUM_REQ];
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W:0]   scan_sum;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i]  = bus.req_a[8*i +: 8];
            b_arr[i]  = bus.req_b[8*i +: 8];
            op_arr[i] = bus.req_op[4*i +: 4];
        end
    end

    // Scan upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        win_found = 1'b0;
        win_id    = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_sum >= NUM_REQ_W) scan_sum = scan_sum - NUM_REQ_W;
            if (!win_found && bus.req_valid[scan_sum[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan_sum[ID_W-1:0];
            end
        end
    end

    // Gated by rst_n so the grant is also forced low while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state_q == IDLE && win_found) bus.req_ready[win_id] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        err_d      = err_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    alu_a_d   = a_arr[win_id];
                    alu_b_d   = b_arr[win_id];
                    alu_sel_d = op_arr[win_id];
                    id_d      = win_id;
                    err_d     = (op_arr[win_id] == OP_DIV) && (b_arr[win_id] == 8'd0);
                    rr_ptr_d  = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_out;
                rsp_id_d   = id_q;
                rsp_err_d  = err_q;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            err_q      <= err_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_sel       = alu_sel_q;
    assign busy          = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_alu_arbiter;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int glog[$];
    int gcyc[$];

    alu_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

    alu_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_out (alu_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external ALU.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [7:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a * b;
            4'd3:    r = (b == 8'd0) ? 8'd0 : a / b;
            4'd4:    r = a & b;
            4'd5:    r = a | b;
            4'd6:    r = a ^ b;
            4'd15:   r = {7'd0, a == b};
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    assign alu_out = alu_f(alu_a, alu_b, alu_sel);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Model: an operation is outstanding from its accept until the edge where its response is taken.
    bit         m_busy;
    int         m_age;
    int         m_id;
    int         m_ptr;
    logic [7:0] m_a, m_b;
    logic [3:0] m_op;

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_id = 0; m_ptr = 0;
            m_a = 8'd0; m_b = 8'd0; m_op = 4'd0;
        end else if (!m_busy) begin
            w = rr_pick(bus.req_valid, m_ptr);
            if (w >= 0) begin
                m_a    = bus.req_a[8*w +: 8];
                m_b    = bus.req_b[8*w +: 8];
                m_op   = bus.req_op[4*w +: 4];
                m_id   = w;
                m_ptr  = (w + 1) % N;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else if (m_age >= 1 && bus.rsp_ready) begin
            m_busy = 1'b0;
        end else begin
            m_age++;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Compare every cycle at the falling edge; also log accepted grants.
    initial forever begin
        logic [N-1:0] exp_ready;
        bit           exp_valid;
        int           p;
        @(negedge clk);
        cyc++;
        p         = rr_pick(bus.req_valid, m_ptr);
        exp_ready = '0;
        if (rst_n && !m_busy && p >= 0) exp_ready[p] = 1'b1;
        exp_valid = m_busy && (m_age >= 1);
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(m_busy));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        check("alu_a", 32'(alu_a), 32'(m_a));
        check("alu_b", 32'(alu_b), 32'(m_b));
        check("alu_sel", 32'(alu_sel), 32'(m_op));
        if (exp_valid) begin
            check("rsp_data", 32'(bus.rsp_data), 32'(alu_f(m_a, m_b, m_op)));
            check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
            check("rsp_err", 32'(bus.rsp_err), 32'((m_op == 4'd3) && (m_b == 8'd0)));
        end
        if (rst_n && (bus.req_ready & bus.req_valid) != '0) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i]) begin
                    glog.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        bus.req_valid[i]     = 1'b1;
        bus.req_a[8*i +: 8]  = a;
        bus.req_b[8*i +: 8]  = b;
        bus.req_op[4*i +: 4] = op;
    endtask

    task automatic clr_req(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_grant(input int n0);
        int k = 0;
        while (glog.size() <= n0 && k < 40) begin
            tick();
            k++;
        end
        check("grant_wait", 32'(glog.size() > n0), 32'd1);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("rsp_wait", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin
            tick();
            k++;
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    // Single operation from one requester, with literal expected response.
    task automatic do_op(input string name, input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic [7:0] exp_data, input logic exp_err);
        int n0;
        int lat;
        n0 = glog.size();
        set_req(id, a, b, op);
        wait_grant(n0);
        check({name, "_gid"}, 32'(glog[n0]), 32'(id));
        clr_req(id);
        wait_rsp(lat);
        // Response is visible one edge after the accept edge.
        check({name, "_lat"}, 32'(lat), 32'd1);
        check({name, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
        check({name, "_id"}, 32'(bus.rsp_id), 32'(id));
        check({name, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        wait_idle();
    endtask

    initial begin
        int n0, n1, lat;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;

        // All four requesters valid from reset.
        set_req(0, 8'd10, 8'd3, 4'd0);
        set_req(1, 8'd10, 8'd3, 4'd1);
        set_req(2, 8'd10, 8'd3, 4'd2);
        set_req(3, 8'd10, 8'd3, 4'd4);
        tick();
        tick();
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        rst_n = 1'b1;
        begin
            int k = 0;
            while (glog.size() < 5 && k < 40) begin
                tick();
                k++;
            end
        end
        bus.req_valid = '0;
        check("rr_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("rr_order", 32'(glog[i]), 32'(exp_order[i]));
        for (int i = 1; i < 5; i++) check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        wait_idle();

        // Single request from requester 1: 200 + 100 truncates to 44.
        do_op("add", 1, 8'd200, 8'd100, 4'b0000, 8'd44, 1'b0);

        // Grant to 2, then 0 and 3 together: 3 is next in rotation.
        do_op("sub", 2, 8'd7, 8'd3, 4'd1, 8'd4, 1'b0);
        n0 = glog.size();
        set_req(0, 8'hF0, 8'h0F, 4'd5);
        set_req(3, 8'd6, 8'd7, 4'd2);
        wait_grant(n0);
        check("pair_first", 32'(glog[n0]), 32'd3);
        clr_req(3);
        wait_rsp(lat);
        check("pair_mul", 32'(bus.rsp_data), 32'd42);
        wait_idle();
        wait_grant(n0 + 1);
        check("pair_second", 32'(glog[n0+1]), 32'd0);
        clr_req(0);
        wait_rsp(lat);
        check("pair_or", 32'(bus.rsp_data), 32'hFF);
        wait_idle();

        // Divide by zero, then a normal divide.
        do_op("div0", 0, 8'd9, 8'd0, 4'b0011, 8'd0, 1'b1);
        do_op("div", 0, 8'd9, 8'd2, 4'b0011, 8'd4, 1'b0);

        // Back-pressure: response held for 5 cycles; another requester waits.
        bus.rsp_ready = 1'b0;
        n0 = glog.size();
        set_req(3, 8'h5A, 8'h5A, 4'b1111);
        wait_grant(n0);
        clr_req(3);
        wait_rsp(lat);
        set_req(1, 8'd3, 8'd4, 4'd0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_data", 32'(bus.rsp_data), 32'd1);
            check("bp_id", 32'(bus.rsp_id), 32'd3);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        n1 = glog.size();
        bus.rsp_ready = 1'b1;
        tick();
        check("bp_done", 32'(busy), 32'd0);
        wait_grant(n1);
        check("bp_next", 32'(glog[n1]), 32'd1);
        clr_req(1);
        wait_rsp(lat);
        check("bp_next_data", 32'(bus.rsp_data), 32'd7);
        wait_idle();

        // Reset during EXEC discards the operation and resets the rotation.
        n0 = glog.size();
        set_req(2, 8'd1, 8'd2, 4'd0);
        wait_grant(n0);
        #2 rst_n = 1'b0;
        #1;
        check("er_ready", 32'(bus.req_ready), 32'd0);
        check("er_busy", 32'(busy), 32'd0);
        check("er_valid", 32'(bus.rsp_valid), 32'd0);
        check("er_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        check("er_rsp", 32'({bus.rsp_data, bus.rsp_id, bus.rsp_err}), 32'd0);
        clr_req(2);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("er_no_rsp", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        n0 = glog.size();
        set_req(1, 8'h33, 8'h11, 4'd6);
        set_req(3, 8'h80, 8'd2, 4'd2);
        wait_grant(n0);
        check("er_first", 32'(glog[n0]), 32'd1);
        clr_req(1);
        wait_rsp(lat);
        check("er_xor", 32'(bus.rsp_data), 32'h22);
        wait_idle();
        wait_grant(n0 + 1);
        check("er_second", 32'(glog[n0+1]), 32'd3);
        clr_req(3);
        wait_rsp(lat);
        check("er_mul", 32'(bus.rsp_data), 32'd0);
        wait_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
